// File: rtl/noc_traffic_node.sv
// NoC traffic endpoint: injects fixed-length packets toward a programmable
// destination and checks packets arriving on the receive port.
module noc_traffic_node #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NODE_ID    = 0,
    parameter int unsigned PKT_LEN    = 4,
    parameter int unsigned INJECT_GAP = 0,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  noc_clk,
    input  logic                  noc_rst,
    input  logic                  enable,
    input  logic [7:0]            dest_id,
    input  logic [CNT_WIDTH-1:0]  pkt_limit,
    input  logic                  rx_stall,
    output logic                  sender_valid,
    input  logic                  sender_ready,
    output logic [DATA_WIDTH-1:0] sender_flit,
    output logic                  sender_is_header,
    output logic                  sender_is_tail,
    input  logic                  receive_valid,
    output logic                  receive_ready,
    input  logic [DATA_WIDTH-1:0] receive_flit,
    input  logic                  receive_is_header,
    input  logic                  receive_is_tail,
    output logic [CNT_WIDTH-1:0]  tx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  rx_pkt_cnt,
    output logic [CNT_WIDTH-1:0]  rx_err_cnt,
    output logic                  tx_done
);

    localparam logic [7:0] NODE = 8'(NODE_ID);
    localparam logic [7:0] LEN  = 8'(PKT_LEN);
    localparam int unsigned GAP_W = (INJECT_GAP > 1) ? $clog2(INJECT_GAP) : 1;
    // Last gap count value; unreachable when INJECT_GAP is 0.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(INJECT_GAP - 1);

    typedef enum logic [1:0] {TxIdle, TxHead, TxBody, TxGap} tx_state_e;
    typedef enum logic {RxWaitHead, RxBody} rx_state_e;

    // Saturating counter increment; never wraps past all-ones.
    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                     input logic [1:0] b);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH+1)'(b);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Builds a flit: {top, NODE, seq, low} in the low 32 bits, zeros above.
    function automatic logic [DATA_WIDTH-1:0] make_flit(input logic [7:0] top,
                                                        input logic [7:0] seq,
                                                        input logic [7:0] low);
        logic [DATA_WIDTH-1:0] f;
        f       = '0;
        f[31:0] = {top, NODE, seq, low};
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------
    tx_state_e            tx_state;
    logic [7:0]           tx_k;
    logic [7:0]           tx_seq;
    logic [GAP_W-1:0]     gap_cnt;
    logic                 tx_hs;
    logic [CNT_WIDTH-1:0] tx_cnt_inc;
    logic                 limit_now;
    logic                 limit_after;
    logic                 tx_can_start;

    assign tx_hs = sender_valid && sender_ready;

    // Limit evaluation for the present count and for the count after a tail.
    always_comb begin
        tx_cnt_inc   = sat_add(tx_pkt_cnt, 2'd1);
        limit_now    = (pkt_limit != '0) && (tx_pkt_cnt >= pkt_limit);
        limit_after  = (pkt_limit != '0) && (tx_cnt_inc >= pkt_limit);
        tx_can_start = enable && !tx_done && !limit_now;
    end

    // TX FSM with registered flit outputs; outputs only change on handshake.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            tx_state         <= TxIdle;
            tx_k             <= '0;
            tx_seq           <= '0;
            gap_cnt          <= '0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
            tx_pkt_cnt       <= '0;
        end else begin
            case (tx_state)
                TxIdle: begin
                    if (tx_can_start) begin
                        sender_valid     <= 1'b1;
                        sender_flit      <= make_flit(dest_id, tx_seq, LEN);
                        sender_is_header <= 1'b1;
                        sender_is_tail   <= 1'b0;
                        tx_state         <= TxHead;
                    end
                end
                TxHead: begin
                    if (tx_hs) begin
                        tx_k             <= 8'd1;
                        sender_flit      <= make_flit(8'd0, tx_seq, 8'd1);
                        sender_is_header <= 1'b0;
                        sender_is_tail   <= (LEN == 8'd2);
                        tx_state         <= TxBody;
                    end
                end
                TxBody: begin
                    if (tx_hs) begin
                        if (sender_is_tail) begin
                            tx_pkt_cnt     <= tx_cnt_inc;
                            tx_seq         <= tx_seq + 8'd1;
                            sender_is_tail <= 1'b0;
                            if (INJECT_GAP > 0) begin
                                sender_valid <= 1'b0;
                                gap_cnt      <= '0;
                                tx_state     <= TxGap;
                            end else if (enable && !tx_done && !limit_after) begin
                                // Back-to-back: next header uses the advanced seq.
                                sender_flit      <= make_flit(dest_id, tx_seq + 8'd1, LEN);
                                sender_is_header <= 1'b1;
                                tx_state         <= TxHead;
                            end else begin
                                sender_valid <= 1'b0;
                                tx_state     <= TxIdle;
                            end
                        end else begin
                            tx_k           <= tx_k + 8'd1;
                            sender_flit    <= make_flit(8'd0, tx_seq, tx_k + 8'd1);
                            sender_is_tail <= ((tx_k + 8'd1) == (LEN - 8'd1));
                        end
                    end
                end
                TxGap: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (tx_can_start) begin
                            sender_valid     <= 1'b1;
                            sender_flit      <= make_flit(dest_id, tx_seq, LEN);
                            sender_is_header <= 1'b1;
                            tx_state         <= TxHead;
                        end else begin
                            tx_state <= TxIdle;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: tx_state <= TxIdle;
            endcase
        end
    end

    // tx_done follows the count by one cycle and sticks until reset.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            tx_done <= 1'b0;
        end else if (limit_now) begin
            tx_done <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    rx_state_e  rx_state;
    logic [7:0] rx_src;
    logic [7:0] rx_seq;
    logic [7:0] rx_len;
    logic [7:0] rx_k;
    logic       rx_pkt_bad;
    logic       rx_hs;
    logic       rx_dest_bad;
    logic       rx_last;
    logic       rx_flit_bad;
    logic [1:0] rx_err_inc;

    assign receive_ready = !noc_rst && !rx_stall;
    assign rx_hs         = receive_valid && receive_ready;

    // Per-flit error classification; a header in BODY can cost two errors.
    always_comb begin
        rx_dest_bad = (receive_flit[31:24] != NODE);
        rx_last     = (rx_k == (rx_len - 8'd1));
        rx_flit_bad = (receive_flit[23:0] != {rx_src, rx_seq, rx_k}) ||
                      (receive_is_tail != rx_last);
        rx_err_inc  = 2'd0;
        if (rx_hs) begin
            if (receive_is_header) begin
                rx_err_inc = 2'(rx_state == RxBody) + 2'(rx_dest_bad);
            end else if (rx_state == RxWaitHead) begin
                rx_err_inc = 2'd1;
            end else begin
                rx_err_inc = 2'(rx_flit_bad);
            end
        end
    end

    // RX FSM: tracks the expected packet and updates the status counters.
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            rx_state   <= RxWaitHead;
            rx_src     <= '0;
            rx_seq     <= '0;
            rx_len     <= '0;
            rx_k       <= '0;
            rx_pkt_bad <= 1'b0;
            rx_pkt_cnt <= '0;
            rx_err_cnt <= '0;
        end else if (rx_hs) begin
            rx_err_cnt <= sat_add(rx_err_cnt, rx_err_inc);
            if (receive_is_header) begin
                // A bad destination still gets tracked so the body stays in sync.
                rx_src     <= receive_flit[23:16];
                rx_seq     <= receive_flit[15:8];
                rx_len     <= receive_flit[7:0];
                rx_k       <= 8'd1;
                rx_pkt_bad <= rx_dest_bad;
                rx_state   <= RxBody;
            end else if (rx_state == RxBody) begin
                if (rx_flit_bad) begin
                    rx_pkt_bad <= 1'b1;
                end
                if (receive_is_tail || rx_last) begin
                    if (receive_is_tail && !rx_pkt_bad && !rx_flit_bad) begin
                        rx_pkt_cnt <= sat_add(rx_pkt_cnt, 2'd1);
                    end
                    rx_state <= RxWaitHead;
                end else begin
                    rx_k <= rx_k + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_traffic_node.sv
// Bench for noc_traffic_node: loopback and directed receive vectors, checked
// every cycle against a packet-level model plus hand-computed literals.
module tb_noc_traffic_node;

    localparam int DW   = 32;
    localparam int NID  = 3;
    localparam int PLEN = 4;
    localparam int GAP  = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          noc_clk = 1'b0;
    logic          noc_rst = 1'b1;
    logic          enable = 1'b0;
    logic [7:0]    dest_id = 8'd3;
    logic [CW-1:0] pkt_limit = '0;
    logic          rx_stall = 1'b0;
    logic          sender_valid, sender_ready, sender_is_header, sender_is_tail;
    logic [DW-1:0] sender_flit;
    logic          receive_valid, receive_ready, receive_is_header, receive_is_tail;
    logic [DW-1:0] receive_flit;
    logic [CW-1:0] tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;
    logic          tx_done;

    logic          loop = 1'b0;
    logic          tb_rdy = 1'b1;
    logic          rand_on = 1'b0;
    logic          drv_valid = 1'b0;
    logic [DW-1:0] drv_flit = '0;
    logic          drv_hdr = 1'b0;
    logic          drv_tail = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] tx_log[$];

    always #5 noc_clk = ~noc_clk;

    // Loopback: both ends see the same handshake because tb_rdy gates both.
    assign sender_ready      = loop ? (receive_ready & tb_rdy) : tb_rdy;
    assign receive_valid     = loop ? (sender_valid & tb_rdy) : drv_valid;
    assign receive_flit      = loop ? sender_flit : drv_flit;
    assign receive_is_header = loop ? sender_is_header : drv_hdr;
    assign receive_is_tail   = loop ? sender_is_tail : drv_tail;

    noc_traffic_node #(
        .DATA_WIDTH(DW), .NODE_ID(NID), .PKT_LEN(PLEN), .INJECT_GAP(GAP), .CNT_WIDTH(CW)
    ) dut (
        .noc_clk(noc_clk), .noc_rst(noc_rst), .enable(enable), .dest_id(dest_id),
        .pkt_limit(pkt_limit), .rx_stall(rx_stall),
        .sender_valid(sender_valid), .sender_ready(sender_ready), .sender_flit(sender_flit),
        .sender_is_header(sender_is_header), .sender_is_tail(sender_is_tail),
        .receive_valid(receive_valid), .receive_ready(receive_ready),
        .receive_flit(receive_flit), .receive_is_header(receive_is_header),
        .receive_is_tail(receive_is_tail),
        .tx_pkt_cnt(tx_pkt_cnt), .rx_pkt_cnt(rx_pkt_cnt), .rx_err_cnt(rx_err_cnt),
        .tx_done(tx_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    // Ready pattern for the sender side: 50% random when enabled.
    initial begin
        forever begin
            @(posedge noc_clk);
            #1;
            tb_rdy = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Model state
    int          tx_k_m = 0, tx_seq_m = 0, tx_cnt_m = 0, rx_pkt_m = 0, rx_err_m = 0;
    bit          done_m = 0;
    bit          rx_in_pkt = 0, rx_bad_m = 0;
    int          rx_k_m = 0, rx_len_m = 0;
    logic [7:0]  rx_src_m = '0, rx_seq_m = '0;
    bit          gap_arm = 0;
    int          idle_run = 0;
    bit          prev_stall = 0, prev_rst = 1;
    logic [DW-1:0] prev_flit = '0;
    logic        prev_hdr = 0, prev_tail = 0;

    // Compare process: sample mid-cycle, check, then advance the model.
    initial begin
        logic [31:0] exp_flit;
        logic [31:0] f;
        bit          at_end, bad;
        forever begin
            @(negedge noc_clk);
            check("tx_pkt_cnt", 32'(tx_pkt_cnt), tx_cnt_m);
            check("rx_pkt_cnt", 32'(rx_pkt_cnt), rx_pkt_m);
            check("rx_err_cnt", 32'(rx_err_cnt), rx_err_m);
            check("tx_done", 32'(tx_done), 32'(done_m));
            check("receive_ready", 32'(receive_ready), 32'(!noc_rst && !rx_stall));
            if (done_m) check("no_tx_after_done", 32'(sender_valid), 0);
            if (prev_stall && !prev_rst) begin
                check("stall_valid", 32'(sender_valid), 1);
                check("stall_flit", sender_flit, prev_flit);
                check("stall_hdr", 32'(sender_is_header), 32'(prev_hdr));
                check("stall_tail", 32'(sender_is_tail), 32'(prev_tail));
            end
            if (sender_valid) begin
                if (gap_arm) begin
                    check("inject_gap", idle_run, GAP);
                    gap_arm = 0;
                end
            end else begin
                idle_run++;
            end
            done_m = done_m || (pkt_limit != 0 && tx_cnt_m >= int'(pkt_limit));

            if (!noc_rst && sender_valid && sender_ready) begin
                if (tx_k_m == 0)
                    exp_flit = {dest_id, 8'(NID), 8'(tx_seq_m), 8'(PLEN)};
                else
                    exp_flit = {8'd0, 8'(NID), 8'(tx_seq_m), 8'(tx_k_m)};
                check("tx_flit", sender_flit, exp_flit);
                check("tx_is_header", 32'(sender_is_header), 32'(tx_k_m == 0));
                check("tx_is_tail", 32'(sender_is_tail), 32'(tx_k_m == PLEN - 1));
                tx_log.push_back(sender_flit);
                if (tx_k_m == PLEN - 1) begin
                    tx_k_m   = 0;
                    tx_seq_m = (tx_seq_m + 1) % 256;
                    tx_cnt_m = sat(tx_cnt_m + 1);
                    gap_arm  = enable && (pkt_limit == 0 || tx_cnt_m < int'(pkt_limit));
                    idle_run = 0;
                end else begin
                    tx_k_m++;
                end
            end

            if (!noc_rst && receive_valid && receive_ready) begin
                f = receive_flit;
                if (receive_is_header) begin
                    if (rx_in_pkt) rx_err_m = sat(rx_err_m + 1);
                    rx_bad_m = (f[31:24] != 8'(NID));
                    if (rx_bad_m) rx_err_m = sat(rx_err_m + 1);
                    rx_in_pkt = 1;
                    rx_src_m  = f[23:16];
                    rx_seq_m  = f[15:8];
                    rx_len_m  = int'(f[7:0]);
                    rx_k_m    = 1;
                end else if (!rx_in_pkt) begin
                    rx_err_m = sat(rx_err_m + 1);
                end else begin
                    at_end = (rx_k_m == rx_len_m - 1);
                    bad = (f[23:0] != {rx_src_m, rx_seq_m, 8'(rx_k_m)}) ||
                          (receive_is_tail != at_end);
                    if (bad) begin
                        rx_err_m = sat(rx_err_m + 1);
                        rx_bad_m = 1;
                    end
                    if (receive_is_tail && !rx_bad_m) rx_pkt_m = sat(rx_pkt_m + 1);
                    if (receive_is_tail || at_end) rx_in_pkt = 0;
                    else rx_k_m++;
                end
            end

            if (noc_rst) begin
                tx_k_m = 0; tx_seq_m = 0; tx_cnt_m = 0; rx_pkt_m = 0; rx_err_m = 0;
                done_m = 0; rx_in_pkt = 0; rx_bad_m = 0; gap_arm = 0;
            end
            prev_stall = sender_valid && !sender_ready;
            prev_flit  = sender_flit;
            prev_hdr   = sender_is_header;
            prev_tail  = sender_is_tail;
            prev_rst   = noc_rst;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge noc_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        noc_rst = 1'b1;
        enable  = 1'b0;
        step(2);
        noc_rst = 1'b0;
        tx_log.delete();
    endtask

    task automatic send_rx(input logic [31:0] flit, input logic hdr, input logic tail);
        drv_valid = 1'b1;
        drv_flit  = flit;
        drv_hdr   = hdr;
        drv_tail  = tail;
        step();
        drv_valid = 1'b0;
        drv_hdr   = 1'b0;
        drv_tail  = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !tx_done; i++) step();
        check("tx_done_reached", 32'(tx_done), 1);
    endtask

    logic [31:0] exp_list [8];

    initial begin
        exp_list[0] = 32'h0303_0004; exp_list[1] = 32'h0003_0001;
        exp_list[2] = 32'h0003_0002; exp_list[3] = 32'h0003_0003;
        exp_list[4] = 32'h0303_0104; exp_list[5] = 32'h0003_0101;
        exp_list[6] = 32'h0003_0102; exp_list[7] = 32'h0003_0103;

        // Reset state, sampled while reset is still asserted
        step(2);
        check("rst_sender_valid", 32'(sender_valid), 0);
        check("rst_sender_flit", sender_flit, 0);
        check("rst_is_header", 32'(sender_is_header), 0);
        check("rst_is_tail", 32'(sender_is_tail), 0);
        check("rst_receive_ready", 32'(receive_ready), 0);
        check("rst_counts", {20'd0, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt}, 0);
        check("rst_tx_done", 32'(tx_done), 0);
        noc_rst = 1'b0;

        // Loopback, ready always high, two packets
        loop = 1'b1; dest_id = 8'd3; pkt_limit = 4'd2; enable = 1'b1;
        wait_done(200);
        step(5);
        check("lb_log_size", tx_log.size(), 8);
        for (int i = 0; i < 8; i++) check("lb_flit", tx_log[i], exp_list[i]);
        check("lb_tx_cnt", 32'(tx_pkt_cnt), 2);
        check("lb_rx_cnt", 32'(rx_pkt_cnt), 2);
        check("lb_err_cnt", 32'(rx_err_cnt), 0);
        check("lb_sender_idle", 32'(sender_valid), 0);

        // Loopback with random backpressure
        do_reset();
        rand_on = 1'b1; pkt_limit = 4'd2; enable = 1'b1;
        wait_done(400);
        rand_on = 1'b0;
        step(5);
        check("rnd_log_size", tx_log.size(), 8);
        for (int i = 0; i < 8; i++) check("rnd_flit", tx_log[i], exp_list[i]);
        check("rnd_rx_cnt", 32'(rx_pkt_cnt), 2);
        check("rnd_err_cnt", 32'(rx_err_cnt), 0);

        // Reset after two of four flits, then restart from seq 0
        do_reset();
        pkt_limit = 4'd0; enable = 1'b1;
        for (int i = 0; i < 50 && tx_log.size() < 2; i++) step();
        check("mid_two_flits", tx_log.size(), 2);
        noc_rst = 1'b1;
        step();
        check("mid_rst_valid", 32'(sender_valid), 0);
        check("mid_rst_flit", sender_flit, 0);
        check("mid_rst_flags", {30'd0, sender_is_header, sender_is_tail}, 0);
        check("mid_rst_counts", {20'd0, tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt}, 0);
        check("mid_rst_ready", 32'(receive_ready), 0);
        noc_rst = 1'b0;
        tx_log.delete();
        pkt_limit = 4'd1;
        wait_done(100);
        step(3);
        check("restart_header", tx_log[0], 32'h0303_0004);
        check("restart_tx_cnt", 32'(tx_pkt_cnt), 1);
        check("restart_rx_cnt", 32'(rx_pkt_cnt), 1);
        check("restart_err_cnt", 32'(rx_err_cnt), 0);

        // Enable dropped right after the header handshake
        do_reset();
        pkt_limit = 4'd0; enable = 1'b1;
        for (int i = 0; i < 50 && tx_log.size() < 1; i++) step();
        enable = 1'b0;
        step(20);
        check("en_drop_log", tx_log.size(), 4);
        check("en_drop_valid", 32'(sender_valid), 0);
        check("en_drop_tx_cnt", 32'(tx_pkt_cnt), 1);
        check("en_drop_rx_cnt", 32'(rx_pkt_cnt), 1);

        // Directed receive: corrupted body flit, then a clean packet
        do_reset();
        loop = 1'b0;
        send_rx(32'h0303_0004, 1, 0); send_rx(32'h0003_0001, 0, 0);
        send_rx(32'h0003_0005, 0, 0); send_rx(32'h0003_0003, 0, 1);
        check("corrupt_err", 32'(rx_err_cnt), 1);
        check("corrupt_pkt", 32'(rx_pkt_cnt), 0);
        send_rx(32'h0303_0504, 1, 0); send_rx(32'h0003_0501, 0, 0);
        send_rx(32'h0003_0502, 0, 0); send_rx(32'h0003_0503, 0, 1);
        check("clean_pkt", 32'(rx_pkt_cnt), 1);
        check("clean_err", 32'(rx_err_cnt), 1);

        // Bad dest, early tail, headerless flit, truncated packet
        do_reset();
        send_rx(32'h0703_0004, 1, 0); send_rx(32'h0003_0001, 0, 0);
        send_rx(32'h0003_0002, 0, 0); send_rx(32'h0003_0003, 0, 1);
        check("bad_dest_err", 32'(rx_err_cnt), 1);
        check("bad_dest_pkt", 32'(rx_pkt_cnt), 0);
        send_rx(32'h0303_0004, 1, 0); send_rx(32'h0003_0001, 0, 0);
        send_rx(32'h0003_0002, 0, 1);
        check("early_tail_err", 32'(rx_err_cnt), 2);
        send_rx(32'h0003_0001, 0, 0);
        check("headerless_err", 32'(rx_err_cnt), 3);
        send_rx(32'h0303_0104, 1, 0); send_rx(32'h0003_0101, 0, 0);
        send_rx(32'h0303_0204, 1, 0);
        check("truncated_err", 32'(rx_err_cnt), 4);
        send_rx(32'h0003_0201, 0, 0); send_rx(32'h0003_0202, 0, 0);
        send_rx(32'h0003_0203, 0, 1);
        check("after_trunc_pkt", 32'(rx_pkt_cnt), 1);

        // Receive backpressure
        rx_stall = 1'b1;
        step();
        check("stall_ready", 32'(receive_ready), 0);
        send_rx(32'h0003_0001, 0, 0);
        step();
        check("stall_no_count", 32'(rx_err_cnt), 4);
        rx_stall = 1'b0;
        step();

        // Error counter saturates at all-ones
        do_reset();
        for (int i = 0; i < 20; i++) send_rx(32'h0003_0001, 0, 0);
        step();
        check("err_saturate", 32'(rx_err_cnt), CMAX);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
